// File: rtl/dmem_responder.sv
// Data-memory slave for the core load/store port: one request at a time, byte-lane writes,
// LATENCY wait states, then a registered one-cycle Ready (with Err) while Stall holds the core.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  ByteEn,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] RData,
    output logic        Ready,
    output logic        Err,
    output logic        Stall
);
    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_L   = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          write_q;
    logic          bad_q;
    logic [31:0]   rdata_q;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic req;
    logic accept;
    logic enter_resp;
    logic mem_we;
    logic rd_load;
    logic unused_addr_lsb;

    assign req             = MemRead | MemWrite;
    assign unused_addr_lsb = ^Addr[1:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            bad_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            // Request is frozen at acceptance; later input changes are ignored until IDLE.
            if (accept) begin
                idx_q   <= Addr[AW+1:2];
                wdata_q <= WData;
                be_q    <= ByteEn;
                write_q <= MemWrite;
                bad_q   <= (MemRead & MemWrite) | (Addr[31:2] >= DEPTH_L);
            end
            if (rd_load) begin
                rdata_q <= mem_q[idx_q];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = WAIT;
            WAIT:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept     = (state_q == IDLE) && req;
        enter_resp = (state_q == WAIT) && (cnt_q == 4'd0);
        cnt_d      = cnt_q;
        if (accept) begin
            cnt_d = LAT_L;
        end else if ((state_q == WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        ready_d = enter_resp;
        err_d   = enter_resp & bad_q;
        mem_we  = enter_resp & write_q & ~bad_q;
        rd_load = enter_resp & ~write_q & ~bad_q;
    end

    // Backing array has no reset so it can map onto RAM.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign RData = rdata_q;
    assign Ready = ready_q;
    assign Err   = err_q;
    assign Stall = req & ~ready_q;
endmodule
